// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch stage: word type, FSM encoding, PC step.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

  // Word-align an address by clearing the byte-offset bits.
  function automatic word_t align_word(input word_t addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: icache request/response, decode-side instruction
// slot, redirect/halt controls and the optional perf counter outputs.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t iload;
  logic  iREN;
  word_t iaddr;
  word_t instr;
  word_t npc;
  logic  instr_valid;
  logic  stall;
  logic  redirect;
  word_t redirect_pc;
  logic  halt;
  word_t fetch_cnt;
  word_t stall_cnt;

  // The fetch unit itself.
  modport master (
    input  ihit, iload, stall, redirect, redirect_pc, halt,
    output iREN, iaddr, instr, npc, instr_valid, fetch_cnt, stall_cnt
  );

  // Cache plus decode/execute environment around the fetch unit.
  modport slave (
    output ihit, iload, stall, redirect, redirect_pc, halt,
    input  iREN, iaddr, instr, npc, instr_valid, fetch_cnt, stall_cnt
  );
endinterface

// File: rtl/fetch_unit_perf_ctr.sv
// Saturating 32-bit event counter; holds its value while freeze is high.
module fetch_perf_ctr
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  inc,
  input  logic  freeze,
  output word_t count
);

  // Count up on inc, sticking at all-ones instead of wrapping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (inc && !freeze && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, requests words from the icache and
// presents one registered instruction slot to decode.
// Optional build macro: FETCH_PERF_EN adds fetched/stalled cycle counters.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000,
  parameter int    ADDR_W  = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  fetch_unit_if.master bus
);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  word_t             instr_reg, instr_next;
  word_t             npc_reg, npc_next;
  logic              valid_reg, valid_next;
  logic              slot_free;
  logic              ren;
  logic              fill;

  // Read request: only while running, with room in the slot, and when no
  // redirect/halt is about to discard whatever comes back.
  always_comb begin
    slot_free = ~valid_reg | ~bus.stall;
    ren       = (state_reg == RUN) & slot_free & ~bus.redirect & ~bus.halt;
    fill      = ren & bus.ihit;
  end

  // Next-state and datapath: halt beats redirect beats fill beats consume.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    npc_next   = npc_reg;
    valid_next = valid_reg;
    if (state_reg == RUN) begin
      if (bus.halt) begin
        state_next = HALTED;
        valid_next = 1'b0;
      end else if (bus.redirect) begin
        pc_next    = align_word(bus.redirect_pc);
        valid_next = 1'b0;
      end else if (fill) begin
        instr_next = bus.iload;
        npc_next   = pc_reg + PC_STEP;
        pc_next    = pc_reg + PC_STEP;
        valid_next = 1'b1;
      end else if (valid_reg && !bus.stall) begin
        valid_next = 1'b0;
      end
    end
  end

  // State and slot registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg <= RUN;
      pc_reg    <= PC_INIT;
      instr_reg <= '0;
      npc_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      npc_reg   <= npc_next;
      valid_reg <= valid_next;
    end
  end

  assign bus.iREN        = ren;
  assign bus.iaddr       = pc_reg;
  assign bus.instr       = instr_reg;
  assign bus.npc         = npc_reg;
  assign bus.instr_valid = valid_reg;

`ifdef FETCH_PERF_EN
  logic halted;
  assign halted = (state_reg == HALTED);

  fetch_perf_ctr u_fetch_ctr (
    .CLK    (CLK),
    .nRST   (nRST),
    .inc    (fill),
    .freeze (halted),
    .count  (bus.fetch_cnt)
  );

  fetch_perf_ctr u_stall_ctr (
    .CLK    (CLK),
    .nRST   (nRST),
    .inc    (valid_reg & bus.stall),
    .freeze (halted),
    .count  (bus.stall_cnt)
  );
`else
  assign bus.fetch_cnt = '0;
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (PC_INIT 0 and 32'hFFFF_FFFC) driven by
// the same directed stimulus, checked every cycle against a slot-level model
// plus hand-computed literal expectations.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  nRST;
  logic  t_ihit, t_stall, t_redirect, t_halt;
  word_t t_rpc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  // Instruction memory contents as a function of address.
  function automatic word_t word_of(input word_t a);
    if (a == 32'h0000_0008) return 32'h2402_0005;
    return a ^ 32'hDEAD_0000;
  endfunction

  fetch_unit_if bus0 ();
  fetch_unit_if bus1 ();

  assign bus0.ihit = t_ihit;       assign bus1.ihit = t_ihit;
  assign bus0.stall = t_stall;     assign bus1.stall = t_stall;
  assign bus0.redirect = t_redirect; assign bus1.redirect = t_redirect;
  assign bus0.redirect_pc = t_rpc; assign bus1.redirect_pc = t_rpc;
  assign bus0.halt = t_halt;       assign bus1.halt = t_halt;
  assign bus0.iload = word_of(bus0.iaddr);
  assign bus1.iload = word_of(bus1.iaddr);

  fetch_unit #(.PC_INIT(32'h0000_0000), .ADDR_W(32)) dut0 (
    .CLK (CLK), .nRST (nRST), .bus (bus0)
  );
  fetch_unit #(.PC_INIT(32'hFFFF_FFFC), .ADDR_W(32)) dut1 (
    .CLK (CLK), .nRST (nRST), .bus (bus1)
  );

  // ---------------- behavioural model ----------------
  word_t m_init [2] = '{32'h0000_0000, 32'hFFFF_FFFC};
  word_t m_pc [2], m_instr [2], m_npc [2], m_fc [2], m_sc [2];
  logic  m_valid [2], m_halted [2];

  function automatic logic exp_ren(input int k);
    return !m_halted[k] && (!m_valid[k] || !t_stall) && !t_redirect && !t_halt;
  endfunction

  always @(posedge CLK or negedge nRST) begin
    for (int k = 0; k < 2; k++) begin
      if (!nRST) begin
        m_pc[k] = m_init[k]; m_instr[k] = '0; m_npc[k] = '0;
        m_valid[k] = 1'b0; m_halted[k] = 1'b0; m_fc[k] = '0; m_sc[k] = '0;
      end else if (!m_halted[k]) begin
        logic fetched;
        fetched = exp_ren(k) && t_ihit;
        if (fetched && m_fc[k] != 32'hFFFF_FFFF) m_fc[k] = m_fc[k] + 1;
        if (m_valid[k] && t_stall && m_sc[k] != 32'hFFFF_FFFF) m_sc[k] = m_sc[k] + 1;
        if (t_halt) begin
          m_halted[k] = 1'b1; m_valid[k] = 1'b0;
        end else if (t_redirect) begin
          m_pc[k] = t_rpc & ~32'd3; m_valid[k] = 1'b0;
        end else if (fetched) begin
          m_instr[k] = word_of(m_pc[k]);
          m_npc[k]   = m_pc[k] + 32'd4;
          m_pc[k]    = m_pc[k] + 32'd4;
          m_valid[k] = 1'b1;
        end else if (m_valid[k] && !t_stall) begin
          m_valid[k] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_dut(input int k, input logic ren, input word_t addr,
                         input word_t ins, input word_t np, input logic v,
                         input word_t fc, input word_t sc);
    word_t efc, esc;
`ifdef FETCH_PERF_EN
    efc = m_fc[k]; esc = m_sc[k];
`else
    efc = '0; esc = '0;
`endif
    chk($sformatf("dut%0d.iREN", k), {31'd0, ren}, {31'd0, exp_ren(k)});
    chk($sformatf("dut%0d.iaddr", k), addr, m_pc[k]);
    chk($sformatf("dut%0d.instr_valid", k), {31'd0, v}, {31'd0, m_valid[k]});
    chk($sformatf("dut%0d.instr", k), ins, m_instr[k]);
    chk($sformatf("dut%0d.npc", k), np, m_npc[k]);
    chk($sformatf("dut%0d.fetch_cnt", k), fc, efc);
    chk($sformatf("dut%0d.stall_cnt", k), sc, esc);
  endtask

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge CLK) begin
    cmp_dut(0, bus0.iREN, bus0.iaddr, bus0.instr, bus0.npc, bus0.instr_valid,
            bus0.fetch_cnt, bus0.stall_cnt);
    cmp_dut(1, bus1.iREN, bus1.iaddr, bus1.instr, bus1.npc, bus1.instr_valid,
            bus1.fetch_cnt, bus1.stall_cnt);
  end

  // One clock of stimulus; inputs change 1 time unit after the edge.
  task automatic cyc(input logic h, input logic s, input logic r,
                     input word_t rp, input logic ht);
    t_ihit = h; t_stall = s; t_redirect = r; t_rpc = rp; t_halt = ht;
    @(posedge CLK);
    #1;
    $display("cyc t=%0t ihit=%b stall=%b redir=%b rpc=%h halt=%b | iaddr0=%h v0=%b instr0=%h npc0=%h iaddr1=%h",
             $time, h, s, r, rp, ht, bus0.iaddr, bus0.instr_valid, bus0.instr,
             bus0.npc, bus1.iaddr);
  endtask

  initial begin
    word_t exp_fc, exp_sc;
    nRST = 1'b0;
    t_ihit = 0; t_stall = 0; t_redirect = 0; t_rpc = '0; t_halt = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("lit.reset_iaddr0", bus0.iaddr, 32'h0);
    chk("lit.reset_iaddr1", bus1.iaddr, 32'hFFFF_FFFC);
    chk("lit.reset_valid0", {31'd0, bus0.instr_valid}, 32'd0);
    nRST = 1'b1;

    cyc(1, 0, 0, '0, 0);
    chk("lit.first_instr", bus0.instr, 32'hDEAD_0000);
    chk("lit.first_npc", bus0.npc, 32'h4);
    chk("lit.first_valid", {31'd0, bus0.instr_valid}, 32'd1);
    chk("lit.wrap_npc", bus1.npc, 32'h0);
    chk("lit.wrap_iaddr", bus1.iaddr, 32'h0);
    cyc(1, 0, 0, '0, 0);
    chk("lit.iaddr_8", bus0.iaddr, 32'h8);
    cyc(1, 0, 0, '0, 0);
    chk("lit.instr_at_8", bus0.instr, 32'h2402_0005);
    chk("lit.npc_at_8", bus0.npc, 32'hC);

    repeat (3) cyc(1, 1, 0, '0, 0);
    chk("lit.stall_instr", bus0.instr, 32'h2402_0005);
    chk("lit.stall_npc", bus0.npc, 32'hC);
    chk("lit.stall_iaddr", bus0.iaddr, 32'hC);

    cyc(1, 0, 0, '0, 0);
    chk("lit.release_instr", bus0.instr, 32'hDEAD_000C);
    chk("lit.release_iaddr", bus0.iaddr, 32'h10);
    cyc(1, 1, 0, '0, 0);
    cyc(0, 0, 0, '0, 0);
    cyc(0, 0, 0, '0, 0);

    cyc(1, 0, 1, 32'h0000_0103, 0);
    chk("lit.redir_iaddr", bus0.iaddr, 32'h100);
    chk("lit.redir_valid", {31'd0, bus0.instr_valid}, 32'd0);
    chk("lit.redir_instr_kept", bus0.instr, 32'hDEAD_000C);

    repeat (6) cyc(1, 0, 0, '0, 0);
    chk("lit.after_hits_iaddr", bus0.iaddr, 32'h118);
`ifdef FETCH_PERF_EN
    exp_fc = 32'd10; exp_sc = 32'd4;
`else
    exp_fc = 32'd0; exp_sc = 32'd0;
`endif
    chk("lit.fetch_cnt", bus0.fetch_cnt, exp_fc);
    chk("lit.stall_cnt", bus0.stall_cnt, exp_sc);

    cyc(1, 0, 1, 32'h0000_0200, 1);
    chk("lit.halt_iaddr", bus0.iaddr, 32'h118);
    chk("lit.halt_valid", {31'd0, bus0.instr_valid}, 32'd0);
    repeat (3) cyc(1, 0, 1, 32'h0000_0300, 0);
    chk("lit.halted_iaddr", bus0.iaddr, 32'h118);
    chk("lit.halted_iren", {31'd0, bus0.iREN}, 32'd0);
    chk("lit.halted_fetch_cnt", bus0.fetch_cnt, exp_fc);

    // Reset in the middle of a miss, then confirm fetch restarts at PC_INIT.
    cyc(0, 0, 0, '0, 0);
    #2 nRST = 1'b0;
    #1;
    chk("lit.midreset_iaddr0", bus0.iaddr, 32'h0);
    chk("lit.midreset_iaddr1", bus1.iaddr, 32'hFFFF_FFFC);
    @(posedge CLK);
    #1 nRST = 1'b1;
    cyc(0, 0, 0, '0, 0);
    chk("lit.restart_iren", {31'd0, bus0.iREN}, 32'd1);
    chk("lit.restart_iaddr", bus0.iaddr, 32'h0);
    cyc(1, 0, 0, '0, 0);
    chk("lit.restart_fetch", bus0.instr, 32'hDEAD_0000);

    @(negedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit; owns the program counter.
- Issues word reads to the instruction cache (iREN/iaddr, completed by ihit).
- Latches the returned word into a registered instr/npc/valid output consumed by decode.
- Handles downstream stall, jump/branch redirect from decode/execute, and processor halt.

Parameters:
- PC_INIT, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC and address width (only 32 supported; bits [1:0] always 0).

Ports:
- CLK  input  1  clock
- nRST  input  1  asynchronous, active-low reset
- ihit  input  1  instruction cache hit; iload valid this cycle
- iload  input  32  instruction word from cache
- iREN  output  1  instruction read request (combinational)
- iaddr  output  32  fetch address (= pc)
- instr  output  32  latched instruction to control unit
- npc  output  32  address of instr + 4 (JAL link value)
- instr_valid  output  1  instr/npc hold a live instruction
- stall  input  1  decode cannot accept instr this cycle
- redirect  input  1  take redirect_pc (jump/JR/taken branch)
- redirect_pc  input  32  new PC; bits [1:0] ignored and forced to 0
- halt  input  1  HALT decoded; freeze fetch
- fetch_cnt  output  32  instructions delivered (FETCH_PERF_EN only, else 0)
- stall_cnt  output  32  cycles instr_valid&stall (FETCH_PERF_EN only, else 0)

Behaviour:
- Reset (async): pc=PC_INIT, instr=0, npc=0, instr_valid=0, state=RUN, counters=0.
- States: RUN, HALTED. RUN->HALTED when halt=1. HALTED exits only on reset.
- Definitions: consume = instr_valid & ~stall; slot_free = ~instr_valid | ~stall.
- iREN = (state==RUN) & slot_free & ~redirect & ~halt. iaddr = pc always.
- Per-clock priority, highest first:
  - halt: state<=HALTED, instr_valid<=0, pc unchanged, ihit ignored.
  - redirect: pc<=redirect_pc & ~3, instr_valid<=0, ihit ignored (in-flight miss dropped; cache re-targets on the new iaddr).
  - iREN & ihit: instr<=iload, npc<=pc+4, instr_valid<=1, pc<=pc+4.
  - consume with no fill: instr_valid<=0.
  - otherwise: hold all registers.
- Latency: one cycle from ihit to instr_valid. Back-to-back hits with stall=0 deliver one instruction per cycle.
- stall with instr_valid=1: iREN=0; instr/npc held stable and never overwritten.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- ihit while iREN=0: ignored.
- In HALTED: iREN=0, instr_valid=0; all inputs ignored.
- Reset mid-miss: immediate return to reset values; the next cycle fetches PC_INIT.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: fetch_cnt increments on each cycle with iREN&ihit&~redirect&~halt. stall_cnt increments on each cycle with instr_valid&stall. Both counters saturate at 32'hFFFF_FFFF and freeze in HALTED.
- Undefined: no counter logic; fetch_cnt and stall_cnt tied to 0. The port list is unchanged.

Decomposition:
- cpu_types_pkg adds: word_t (32-bit), WORD_W=32, fetch_state_t enum {RUN, HALTED}, PC_STEP=32'd4.
- One sub-module, fetch_perf_ctr: saturating 32-bit counter with inc and freeze inputs. Instantiated twice, under FETCH_PERF_EN only.

Test Plan:
- Reset with PC_INIT=0 and ihit=1 every cycle, iload=pc-derived words -> iaddr 0,4,8,C on successive cycles; instr follows one cycle later; npc=iaddr+4; instr_valid=1 from cycle 2.
- stall=1 for 3 cycles while instr=32'h2402_0005 -> iREN=0; instr/npc/pc unchanged. On release, the next fetch is at the held pc.
- Redirect: redirect=1, redirect_pc=32'h0000_0103 during a miss (ihit=0) -> next iaddr=32'h100, instr_valid=0; a late ihit that same cycle is not latched.
- halt=1 and redirect=1 in the same cycle -> state HALTED, pc unchanged, iREN=0 forever; the following ihit/redirect have no effect.
- PC wrap: PC_INIT=32'hFFFF_FFFC, ihit=1 -> npc=0, next iaddr=0.
- With FETCH_PERF_EN: 10 hits plus 4 stalled cycles -> fetch_cnt=10, stall_cnt=4. Without the macro: both read 0.
